// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter/sequencer for an external single-port sync SRAM.
// Latency: command registered at the acceptance edge; read data returns rd_latency+1 cycles later on rsp_*.
// Backpressure: req_ready is combinational, one port per cycle; a write behind in-flight reads stalls
//   both ports (DRAIN) until the bus turnaround is safe.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/ready/we[1:0]   per-port request handshake and direction (1 = write)
//   req_addr, req_wdata       packed per port: port p at [p*depth +: depth] / [p*width +: width]
//   rsp_valid[1:0], rsp_rdata one-cycle read-data strobe per port, shared data bus
//   sram_*                    registered SRAM command pins; dq_o/dq_oe drive the top-level tristate
module sram_arbiter #(
  parameter int width      = 8,
  parameter int depth      = 19,
  parameter int rd_latency = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_we,
  input  logic [2*depth-1:0]   req_addr,
  input  logic [2*width-1:0]   req_wdata,
  output logic [1:0]           rsp_valid,
  output logic [width-1:0]     rsp_rdata,
  output logic [depth-1:0]     sram_addr,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [width-1:0]     sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [width-1:0]     sram_dq_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   lock_port, lock_port_nxt;
  logic   rr_prio;                       // port currently holding priority

  // Read tag pipeline: stage 0 loaded at each edge, shifts every edge.
  logic [rd_latency-1:0] tag_vld;
  logic [rd_latency-1:0] tag_port;

  logic             win_vld;
  logic             win_port;
  logic             win_we;
  logic [depth-1:0] win_addr;
  logic [width-1:0] win_wdata;
  logic             acc;
  logic             drain_ok;

  // A write may go out once only the oldest tag (if any) remains: that tag's
  // data is captured on the same edge the write command is registered, so the
  // SRAM has released dq before the write drives it.
  assign drain_ok = ~|tag_vld[rd_latency-2:0];

  // Winner selection: locked port while draining, otherwise round-robin.
  always_comb begin
    win_vld  = 1'b0;
    win_port = rr_prio;
    if (state == DRAIN) begin
      win_port = lock_port;
      win_vld  = req_valid[lock_port];
    end else if (req_valid[rr_prio]) begin
      win_port = rr_prio;
      win_vld  = 1'b1;
    end else if (req_valid[~rr_prio]) begin
      win_port = ~rr_prio;
      win_vld  = 1'b1;
    end
  end

  assign win_we    = req_we[win_port];
  assign win_addr  = win_port ? req_addr[depth +: depth]  : req_addr[0 +: depth];
  assign win_wdata = win_port ? req_wdata[width +: width] : req_wdata[0 +: width];

  // Next state and handshake.
  always_comb begin
    state_nxt     = IDLE;
    lock_port_nxt = lock_port;
    acc           = 1'b0;
    req_ready     = 2'b00;
    if (!rst && win_vld) begin
      if (!win_we) begin
        acc       = 1'b1;
        state_nxt = RD;
      end else if (drain_ok) begin
        acc       = 1'b1;
        state_nxt = WR;
      end else begin
        state_nxt     = DRAIN;
        lock_port_nxt = win_port;
      end
    end
    if (acc) begin
      req_ready[win_port] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_port <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_port <= lock_port_nxt;
    end
  end

  // Command registers, RR pointer, tag pipeline and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio    <= 1'b0;
      tag_vld    <= '0;
      tag_port   <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
    end else begin
      if (acc) begin
        rr_prio   <= ~win_port;
        sram_addr <= win_addr;
      end
      if (acc && win_we) begin
        sram_dq_o <= win_wdata;
      end
      sram_ce_n  <= ~acc;
      sram_oe_n  <= ~(acc & ~win_we);
      sram_we_n  <= ~(acc & win_we);
      sram_dq_oe <= acc & win_we;

      tag_vld  <= {tag_vld[rd_latency-2:0], acc & ~win_we};
      tag_port <= {tag_port[rd_latency-2:0], win_port};

      rsp_valid <= 2'b00;
      if (tag_vld[rd_latency-1]) begin
        rsp_valid[tag_port[rd_latency-1]] <= 1'b1;
        rsp_rdata                         <= sram_dq_i;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer for the external single-port synchronous SRAM (19-bit address, 8-bit shared dq, active-low ce_n/oe_n/we_n). It accepts read/write requests from two clients over valid/ready handshakes and issues registered SRAM commands, one per cycle. It tracks in-flight reads with a tag pipeline and returns read data to the owning port. The tristate dq buffer sits at the top level; this block drives dq_o/dq_oe and samples dq_i.

## Interface
- width, 8, SRAM data width
- depth, 19, SRAM address width
- rd_latency, 3, clock edges from read acceptance edge to dq_i capture edge; minimum 2
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- req_valid  in  2  per-port request valid (bit p = port p)
- req_ready  out  2  per-port accept, combinational; at most one bit high
- req_we  in  2  per-port 1 = write, 0 = read
- req_addr  in  2*depth  port p at [p*depth +: depth]
- req_wdata  in  2*width  port p at [p*width +: width]
- rsp_valid  out  2  one-cycle read-data strobe per port
- rsp_rdata  out  width  read data, shared; valid where rsp_valid is high
- sram_addr  out  depth  registered address
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  registered strobes
- sram_dq_o  out  width  registered write data
- sram_dq_oe  out  1  registered; high only in write command cycles
- sram_dq_i  in  width  dq from the pad

## Operation
- Transfer: an acceptance happens on port p at an edge where req_valid[p] & req_ready[p].
- Arbitration: round-robin. The port granted last has lower priority. After reset, port 0 has priority. The pointer updates only on acceptance.
- FSM states:
  - IDLE: no command issued.
  - RD: read issued.
  - WR: write issued.
  - DRAIN: write pending.
- FSM transitions, evaluated each cycle:
  - Winner requests a read: accept, go to RD. Back-to-back reads are allowed.
  - Winner requests a write and the last read acceptance was at least rd_latency edges earlier (or none is outstanding): accept, go to WR.
  - Otherwise go to DRAIN. Grant is locked to that port, req_ready = 0 for both ports, and the other port cannot issue reads. The write is accepted at the first edge the drain condition holds, then WR.
  - No valid request: IDLE.
- Command registers, loaded at the acceptance edge:
  - Read: sram_ce_n = 0, sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Write: sram_ce_n = 0, sram_oe_n = 1, sram_we_n = 0, sram_dq_oe = 1, sram_dq_o = wdata.
  - No acceptance: ce_n/oe_n/we_n = 1, dq_oe = 0; sram_addr and sram_dq_o hold.
- Tag pipeline:
  - rd_latency stages of {valid, port}. Stage 0 is loaded at each edge with {read accepted, port}; the pipeline shifts every edge.
  - At the edge where a tag leaves the last stage, sram_dq_i is registered into rsp_rdata and rsp_valid[port] is set for one cycle.
- Bus turnaround: the drain rule guarantees we_n stays high and the SRAM owns dq for every in-flight read. A read accepted the edge after a write is legal and returns the newly written data.
- Reset (asserted any time, including mid-read):
  - Clears the FSM to IDLE, the pipeline and the RR pointer.
  - In-flight reads are dropped; no rsp_valid is asserted for them.
  - Output reset values: sram_ce_n/oe_n/we_n = 1, sram_addr = 0, sram_dq_o = 0, sram_dq_oe = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0.

## Timing
- Read accepted at edge A:
  - Command is on the pins A..A+1 and the SRAM samples it at A+1.
  - Data is captured at A+rd_latency; rsp_valid is high in the cycle after edge A+rd_latency.
  - Throughput is 1 read/cycle.
- Write accepted at edge W: the command is on the pins W..W+1 and the SRAM writes at W+1.
- Read→write gap: at least rd_latency edges. Write→read gap: 0 idle cycles.
- req_ready depends combinationally on req_valid, req_we, the FSM state and the pipeline; it never depends on rsp signals.

## Test plan
- Port 0 only: write 0x5A to 0x00010, then read 0x00010. Require the read accepted the edge after the write, rsp_valid[0] high for 1 cycle 3 edges after the read accept, and rsp_rdata = 0x5A.
- Both ports hold valid reads for 8 cycles. Require grants to alternate 0,1,0,1…, one accept per cycle, and responses in order with the correct port bits.
- Port 0 reads 0x00001 at edge A; port 1 requests a write at A+1. Require req_ready = 0 until edge A+3, write accepted at A+3, sram_dq_oe never high while a read tag is in the pipeline, and the read returns the correct data.
- Boundary addresses: write 0xFF at 0x7FFFF and 0x11 at 0x00000, then read both. Require the respective data; no aliasing.
- Assert rst asynchronously (mid-cycle) with 2 reads in flight. Require all outputs at reset values immediately, no rsp_valid afterwards, and port 0 granted first after release.
- Port 1 write in DRAIN while port 0 keeps req_valid for reads. Require port 0 blocked, port 1 write completed, then port 0 granted.
